// File: rtl/alu_bist_pkg.sv
// Shared definitions for the ALU BIST controller: opcodes, FSM encoding, LFSR taps, golden model.
// Latency: none (types and pure functions only); backpressure: not applicable.
package alu_bist_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_GEN   = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_CHECK = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    // Fibonacci taps x^16 + x^14 + x^13 + x^11 -> state bits 15, 13, 12, 10
    localparam logic [15:0] LFSR_TAPS         = 16'hB400;
    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

    typedef struct packed {
        logic       overflow;
        logic       zero;
        logic       carry;
        logic [7:0] result;
    } alu_resp_t;

    function automatic alu_resp_t alu_golden(input logic [7:0] a, input logic [7:0] b,
                                             input logic [1:0] op);
        alu_resp_t  r;
        logic [8:0] wide;
        r    = '0;
        wide = '0;
        case (op)
            OP_ADD: begin
                wide       = {1'b0, a} + {1'b0, b};
                r.overflow = (a[7] == b[7]) && (wide[7] != a[7]);
            end
            OP_SUB: begin
                wide       = {1'b0, a} - {1'b0, b};
                r.overflow = (a[7] != b[7]) && (wide[7] != a[7]);
            end
            OP_AND:  wide = {1'b0, a & b};
            default: wide = {1'b0, a | b};
        endcase
        r.result = wide[7:0];
        r.carry  = wide[8];
        r.zero   = (wide[7:0] == 8'h00);
        return r;
    endfunction

endpackage

// File: rtl/alu_8bit_bist_ctrl_if.sv
// Stimulus/response bus between the BIST controller (master) and the ALU under test (slave).
// Latency: wires only; backpressure: none, the ALU is a fixed one-cycle pipeline.
interface alu_8bit_bist_ctrl_if;

    logic [7:0] alu_A;
    logic [7:0] alu_B;
    logic [1:0] alu_op;
    logic [7:0] alu_result;
    logic       alu_carry;
    logic       alu_zero;
    logic       alu_overflow;

    modport master (
        output alu_A, alu_B, alu_op,
        input  alu_result, alu_carry, alu_zero, alu_overflow
    );

    modport slave (
        input  alu_A, alu_B, alu_op,
        output alu_result, alu_carry, alu_zero, alu_overflow
    );

endinterface

// File: rtl/alu_bist_lfsr16.sv
// 16-bit Fibonacci LFSR, shift left with feedback into bit 0; load has priority over step.
// Latency: new state visible one cycle after load/step; backpressure: none.
module alu_bist_lfsr16
    import alu_bist_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        step,
    input  logic [15:0] seed,
    output logic [15:0] state
);

    logic [15:0] state_q;
    logic [15:0] state_d;

    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = seed;
        end else if (step) begin
            state_d = {state_q[14:0], ^(state_q & LFSR_TAPS)};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= seed;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/alu_8bit_bist_ctrl.sv
// BIST master for the 8-bit ALU: 3 cycles per vector (GEN, WAIT, CHECK); no backpressure, start ignored while busy.
// Optional ALU_BIST_STOP_ON_FAIL_EN ends the run at the first mismatching vector.
module alu_8bit_bist_ctrl
    import alu_bist_pkg::*;
#(
    parameter int unsigned NUM_VECTORS = 256,
    parameter logic [15:0] LFSR_SEED   = LFSR_DEFAULT_SEED,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    alu_8bit_bist_ctrl_if.master alu,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [CNT_W-1:0]     err_count,
    output logic [15:0]          first_fail_idx
);

    localparam logic [15:0] SEED_EFF = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [15:0] LAST_IDX = 16'(NUM_VECTORS - 1);

    logic [2:0]       state_q,   state_d;
    logic [15:0]      vec_idx_q, vec_idx_d;
    logic [CNT_W-1:0] err_q,     err_d;
    logic [15:0]      ffi_q,     ffi_d;
    logic             pass_q,    pass_d;
    logic [7:0]       a_q,       a_d;
    logic [7:0]       b_q,       b_d;
    logic [1:0]       op_q,      op_d;
    alu_resp_t        exp_q,     exp_d;

    logic        lfsr_load;
    logic        lfsr_step;
    logic [15:0] lfsr_state;
    alu_resp_t   resp;
    logic        mismatch;
    logic        finish;

    alu_bist_lfsr16 u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (lfsr_load),
        .step  (lfsr_step),
        .seed  (SEED_EFF),
        .state (lfsr_state)
    );

    assign resp     = '{overflow: alu.alu_overflow, zero: alu.alu_zero,
                        carry: alu.alu_carry, result: alu.alu_result};
    assign mismatch = (resp != exp_q);

    always_comb begin
        state_d   = state_q;
        vec_idx_d = vec_idx_q;
        err_d     = err_q;
        ffi_d     = ffi_q;
        pass_d    = pass_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        exp_d     = exp_q;
        lfsr_load = 1'b0;
        lfsr_step = 1'b0;
        finish    = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    vec_idx_d = '0;
                    err_d     = '0;
                    ffi_d     = '0;
                    pass_d    = 1'b0;
                    lfsr_load = 1'b1;
                    state_d   = ST_GEN;
                end
            end
            ST_GEN: begin
                a_d       = lfsr_state[7:0];
                b_d       = lfsr_state[15:8];
                op_d      = vec_idx_q[1:0];
                exp_d     = alu_golden(lfsr_state[7:0], lfsr_state[15:8], vec_idx_q[1:0]);
                lfsr_step = 1'b1;
                state_d   = ST_WAIT;
            end
            ST_WAIT: begin
                state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (mismatch) begin
                    if (err_q != {CNT_W{1'b1}}) begin
                        err_d = err_q + CNT_W'(1);
                    end
                    // err_count never returns to zero mid-run, so zero means no earlier failure
                    if (err_q == '0) begin
                        ffi_d = vec_idx_q;
                    end
                end
                finish = (vec_idx_q == LAST_IDX);
`ifdef ALU_BIST_STOP_ON_FAIL_EN
                finish = finish | mismatch;
`endif
                if (finish) begin
                    pass_d  = (err_d == '0);
                    state_d = ST_DONE;
                end else begin
                    vec_idx_d = vec_idx_q + 16'd1;
                    state_d   = ST_GEN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            vec_idx_q <= '0;
            err_q     <= '0;
            ffi_q     <= '0;
            pass_q    <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            exp_q     <= '0;
        end else begin
            state_q   <= state_d;
            vec_idx_q <= vec_idx_d;
            err_q     <= err_d;
            ffi_q     <= ffi_d;
            pass_q    <= pass_d;
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            exp_q     <= exp_d;
        end
    end

    assign alu.alu_A      = a_q;
    assign alu.alu_B      = b_q;
    assign alu.alu_op     = op_q;
    assign busy           = (state_q == ST_GEN) || (state_q == ST_WAIT) || (state_q == ST_CHECK);
    assign done           = (state_q == ST_DONE);
    assign pass           = pass_q;
    assign err_count      = err_q;
    assign first_fail_idx = ffi_q;

endmodule
